input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter: DB_CYCLES, 4, number of consecutive stable synchronized samples required to accept a button edge; legal range 2..65535, other values SHALL cause an elaboration error.
REQ-002 Parameter: BTN_ACTIVE_LOW, 1, 1 = btn_raw reads 0 when pressed (board key), 0 = active-high.
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: btn_raw  input  1  unsynchronized, bouncing enter key.
REQ-006 Port: sw_raw  input  8  unsynchronized guess switches.
REQ-007 Port: enter_pulse  output  1  one-cycle strobe per accepted press; drives game control enter input.
REQ-008 Port: guess  output  8  switch value captured at the accepted press; drives game datapath guess input.
REQ-009 Port: btn_level  output  1  debounced button level, 1 = pressed.
REQ-010 Port: press_count  output  8  number of accepted presses, wraps 255->0.

Function
REQ-011 btn_raw SHALL be polarity-normalized (1 = pressed) then passed through a 2-flop synchronizer; output of second flop is btn_sync.
REQ-012 sw_raw SHALL pass through an 8-bit 2-flop synchronizer; output is sw_sync.
REQ-013 FSM states: S_IDLE, S_PRESS_DB, S_HELD, S_RELEASE_DB; one counter cnt, 16 bits.
REQ-014 S_IDLE: btn_sync=1 -> S_PRESS_DB with cnt<=0; else stay.
REQ-015 S_PRESS_DB: btn_sync=0 -> S_IDLE, cnt<=0 (glitch rejected, no pulse); btn_sync=1 and cnt!=DB_CYCLES-1 -> cnt<=cnt+1; btn_sync=1 and cnt==DB_CYCLES-1 -> S_HELD.
REQ-016 On the S_PRESS_DB->S_HELD edge: enter_pulse<=1, guess<=sw_sync, press_count<=press_count+1 (mod 256), all registered on that same edge.
REQ-017 enter_pulse SHALL be high for exactly one cycle per accepted press and 0 in every other cycle.
REQ-018 guess SHALL change only on the edge that raises enter_pulse; stable in all other cycles, including while switches move.
REQ-019 Latency: raw press sampled by edge N, held steadily -> enter_pulse high in the cycle following edge N+DB_CYCLES+2.
REQ-020 S_HELD: btn_sync=0 -> S_RELEASE_DB, cnt<=0; no pulses while held, however long.
REQ-021 S_RELEASE_DB: btn_sync=1 -> S_HELD (release bounce rejected); btn_sync=0 and cnt==DB_CYCLES-1 -> S_IDLE; else cnt<=cnt+1. Release SHALL never produce a pulse.
REQ-022 btn_level SHALL be 1 in S_HELD and S_RELEASE_DB, 0 in S_IDLE and S_PRESS_DB (combinational decode of state).
REQ-023 Counter SHALL never exceed DB_CYCLES-1; no wrap of cnt.
REQ-024 A press interval shorter than DB_CYCLES synchronized cycles, at any phase, SHALL produce no pulse and no change to guess or press_count.

Reset
REQ-025 Reset SHALL force: FSM=S_RELEASE_DB, cnt=0, btn synchronizer flops=1 (pressed, normalized), sw synchronizer flops=0, enter_pulse=0, guess=0, press_count=0.
REQ-026 Consequence: a button held through reset release SHALL produce no pulse until it is released for DB_CYCLES cycles and pressed again.
REQ-027 Reset asserted mid-debounce or during enter_pulse SHALL drop enter_pulse within the same cycle (asynchronous) and discard the partial press.

Verification (DB_CYCLES=4, BTN_ACTIVE_LOW=1)
REQ-028 Clean press: after reset, btn_raw=1 for 10 cycles, sw_raw=0x5A, then btn_raw=0 held 20 cycles -> exactly one enter_pulse, 7 cycles after first low sample; guess=0x5A; press_count=1; btn_level=1.
REQ-029 Bounce: btn_raw toggles 0/1 every cycle for 12 cycles then stays 0 -> exactly one pulse, 7 cycles after last transition to 0; press_count=1.
REQ-030 Glitch: btn_raw low for 3 cycles only -> no pulse, guess and press_count unchanged, btn_level stays 0.
REQ-031 Held through reset: btn_raw=0 before and after reset deassertion for 50 cycles -> no pulse; release 10 cycles then press -> one pulse.
REQ-032 Switch isolation: after one accepted press with sw_raw=0x11, change sw_raw to 0xEE while held and after release -> guess stays 0x11 until next accepted press, then 0xEE.
REQ-033 Wrap: 256 clean presses -> 256 single-cycle pulses, press_count returns to 0x00.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Signal bundle between the board-level inputs and the game logic: raw button/switches in,
// conditioned strobe, captured guess, debounced level and press counter out.
interface input_conditioner_if;
    logic       btn_raw;
    logic [7:0] sw_raw;
    logic       enter_pulse;
    logic [7:0] guess;
    logic       btn_level;
    logic [7:0] press_count;

    modport master (
        output btn_raw,
        output sw_raw,
        input  enter_pulse,
        input  guess,
        input  btn_level,
        input  press_count
    );

    modport slave (
        input  btn_raw,
        input  sw_raw,
        output enter_pulse,
        output guess,
        output btn_level,
        output press_count
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces the enter key, then emits one strobe per accepted press
// together with the switch value captured on that same edge.
module input_conditioner #(
    parameter int unsigned DB_CYCLES      = 4,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    input_conditioner_if.slave  io_bus
);

    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_param_check
        $error("input_conditioner: DB_CYCLES must be in 2..65535");
    end

    localparam logic [15:0] CntMax = 16'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_RELEASE_DB
    } state_e;

    logic        w_btn_norm;
    logic        r_btn_meta;
    logic        r_btn_sync;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic        w_accept;
    logic        w_btn_level;
    logic        r_enter_pulse;
    logic [7:0]  r_guess;
    logic [7:0]  r_press_count;

    assign w_btn_norm = BTN_ACTIVE_LOW ? ~io_bus.btn_raw : io_bus.btn_raw;

    // Button synchronizer resets to "pressed" so a key held through reset is not accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
            r_sw_meta  <= 8'h00;
            r_sw_sync  <= 8'h00;
        end else begin
            r_btn_meta <= w_btn_norm;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= io_bus.sw_raw;
            r_sw_sync  <= r_sw_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RELEASE_DB;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_btn_sync) begin
                    w_state_next = S_PRESS_DB;
                    w_cnt_next   = 16'd0;
                end
            end
            S_PRESS_DB: begin
                if (!r_btn_sync) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 16'd0;
                end else if (r_cnt == CntMax) begin
                    w_state_next = S_HELD;
                    w_cnt_next   = 16'd0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_HELD: begin
                if (!r_btn_sync) begin
                    w_state_next = S_RELEASE_DB;
                    w_cnt_next   = 16'd0;
                end
            end
            S_RELEASE_DB: begin
                if (r_btn_sync) begin
                    w_state_next = S_HELD;
                    w_cnt_next   = 16'd0;
                end else if (r_cnt == CntMax) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 16'd0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    always_comb begin
        w_accept    = (r_state == S_PRESS_DB) && (w_state_next == S_HELD);
        w_btn_level = (r_state == S_HELD) || (r_state == S_RELEASE_DB);
    end

    // Strobe, captured guess and counter all update on the accepting edge only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enter_pulse <= 1'b0;
            r_guess       <= 8'h00;
            r_press_count <= 8'h00;
        end else begin
            r_enter_pulse <= w_accept;
            if (w_accept) begin
                r_guess       <= r_sw_sync;
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    assign io_bus.enter_pulse = r_enter_pulse;
    assign io_bus.guess       = r_guess;
    assign io_bus.btn_level   = w_btn_level;
    assign io_bus.press_count = r_press_count;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: per-cycle comparison against a run-length
// debounce model, a vector table of press lengths, and hand-written corner sequences.
module tb_input_conditioner;

    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic reset;

    input_conditioner_if bus ();

    input_conditioner #(
        .DB_CYCLES      (DB),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Model: a level flips after DB+1 consecutive synchronized samples disagreeing with it.
    logic        m_s1, m_s2;
    logic [7:0]  m_w1, m_w2;
    logic        m_level;
    int unsigned m_run;
    logic        m_pulse;
    logic [7:0]  m_guess;
    logic [7:0]  m_cnt;

    typedef struct {
        int unsigned low_len;
        logic [7:0]  sw;
        int          exp_pulses;
        logic [7:0]  exp_guess;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1;
        m_w1 = 8'h00; m_w2 = 8'h00;
        m_level = 1'b1; m_run = 1;
        m_pulse = 1'b0; m_guess = 8'h00; m_cnt = 8'h00;
    endtask

    task automatic tick();
        logic       sample;
        logic [7:0] old_w2;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            sample  = m_s2;
            old_w2  = m_w2;
            m_pulse = 1'b0;
            if (sample != m_level) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_level = sample;
                    m_run   = 0;
                    if (sample) begin
                        m_pulse = 1'b1;
                        m_guess = old_w2;
                        m_cnt   = m_cnt + 8'd1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1; m_s1 = ~bus.btn_raw;
            m_w2 = m_w1; m_w1 = bus.sw_raw;
        end
        #1;
        if (bus.enter_pulse === 1'b1) pulses++;
        check("cycle{pulse,level,guess,count}",
              {15'd0, bus.enter_pulse, bus.btn_level, bus.guess, bus.press_count},
              {15'd0, m_pulse, m_level, m_guess, m_cnt});
    endtask

    task automatic hold(input logic raw, input int n);
        bus.btn_raw = raw;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Ticks up to 30 cycles; t = tick index of the first pulse, 0 if none.
    task automatic time_to_pulse(output int t);
        t = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.enter_pulse === 1'b1 && t == 0) t = i;
        end
    endtask

    initial begin
        int t;
        int exp_cnt;
        int base;

        vecs[0] = '{3,  8'h33, 0, 8'h5A};
        vecs[1] = '{1,  8'h44, 0, 8'h5A};
        vecs[2] = '{4,  8'h55, 0, 8'h5A};
        vecs[3] = '{5,  8'h66, 1, 8'h66};
        vecs[4] = '{12, 8'h77, 1, 8'h77};
        vecs[5] = '{2,  8'h88, 0, 8'h77};

        bus.btn_raw = 1'b1;
        bus.sw_raw  = 8'h00;
        reset       = 1'b1;
        model_reset();
        #2;
        check("reset_pulse", {31'd0, bus.enter_pulse}, 32'd0);
        check("reset_guess", {24'd0, bus.guess}, 32'd0);
        check("reset_count", {24'd0, bus.press_count}, 32'd0);
        check("reset_level", {31'd0, bus.btn_level}, 32'd1);
        do_reset();
        hold(1'b1, 12);
        check("idle_level", {31'd0, bus.btn_level}, 32'd0);

        // Clean press: pulse 7 ticks after the first low sample
        bus.sw_raw  = 8'h5A;
        hold(1'b1, 2);
        pulses      = 0;
        bus.btn_raw = 1'b0;
        time_to_pulse(t);
        check("clean_latency", t, 32'd7);
        check("clean_pulses", pulses, 32'd1);
        check("clean_guess", {24'd0, bus.guess}, 32'h5A);
        check("clean_count", {24'd0, bus.press_count}, 32'd1);
        check("clean_level", {31'd0, bus.btn_level}, 32'd1);
        hold(1'b1, 12);
        exp_cnt = 1;

        foreach (vecs[k]) begin
            bus.sw_raw = vecs[k].sw;
            hold(1'b1, 3);
            pulses = 0;
            hold(1'b0, int'(vecs[k].low_len));
            hold(1'b1, 12);
            exp_cnt += vecs[k].exp_pulses;
            check($sformatf("vec%0d_pulses", k), pulses, vecs[k].exp_pulses);
            check($sformatf("vec%0d_guess", k), {24'd0, bus.guess}, {24'd0, vecs[k].exp_guess});
            check($sformatf("vec%0d_count", k), {24'd0, bus.press_count}, exp_cnt);
            check($sformatf("vec%0d_level", k), {31'd0, bus.btn_level}, 32'd0);
        end

        // Bounce: alternate every cycle for 12 cycles, then settle low
        bus.sw_raw = 8'hC3;
        pulses = 0;
        for (int i = 0; i < 12; i++) hold(logic'(i % 2), 1);
        bus.btn_raw = 1'b0;
        time_to_pulse(t);
        check("bounce_latency", t, 32'd7);
        check("bounce_pulses", pulses, 32'd1);
        check("bounce_count", {24'd0, bus.press_count}, exp_cnt + 1);
        hold(1'b1, 12);

        // Switch isolation
        bus.sw_raw = 8'h11;
        hold(1'b1, 3);
        hold(1'b0, 20);
        check("iso_first", {24'd0, bus.guess}, 32'h11);
        bus.sw_raw = 8'hEE;
        hold(1'b0, 10);
        check("iso_held", {24'd0, bus.guess}, 32'h11);
        hold(1'b1, 12);
        check("iso_released", {24'd0, bus.guess}, 32'h11);
        hold(1'b0, 20);
        check("iso_second", {24'd0, bus.guess}, 32'hEE);
        hold(1'b1, 12);

        // Held through reset
        bus.btn_raw = 1'b0;
        hold(1'b0, 5);
        do_reset();
        pulses = 0;
        hold(1'b0, 50);
        check("held_reset_nopulse", pulses, 32'd0);
        hold(1'b1, 10);
        hold(1'b0, 20);
        check("held_reset_pulse", pulses, 32'd1);
        check("held_reset_count", {24'd0, bus.press_count}, 32'd1);
        hold(1'b1, 12);

        // Asynchronous reset while the strobe is high
        bus.btn_raw = 1'b0;
        t = 0;
        for (int i = 0; i < 20 && t == 0; i++) begin
            tick();
            if (bus.enter_pulse === 1'b1) t = 1;
        end
        check("async_saw_pulse", t, 32'd1);
        reset = 1'b1;
        #1;
        check("async_pulse_drop", {31'd0, bus.enter_pulse}, 32'd0);
        check("async_count_clr", {24'd0, bus.press_count}, 32'd0);
        model_reset();
        tick();
        reset = 1'b0;
        hold(1'b1, 12);

        // Reset mid-debounce discards the partial press
        pulses = 0;
        hold(1'b0, 4);
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        hold(1'b0, 10);
        hold(1'b1, 12);
        check("middb_pulses", pulses, 32'd0);
        check("middb_count", {24'd0, bus.press_count}, 32'd0);

        // Counter wrap over 256 presses
        base   = int'(bus.press_count);
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            hold(1'b0, 8);
            hold(1'b1, 8);
        end
        check("wrap_pulses", pulses, 32'd256);
        check("wrap_count", {24'd0, bus.press_count}, base);

        // Randomized runs against the model
        for (int i = 0; i < 400; i++) begin
            bus.sw_raw = 8'($urandom);
            hold(logic'($urandom_range(0, 1)), $urandom_range(1, 10));
        end
        hold(1'b1, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
